// File: rtl/mux_4x8_if.sv
// Select/data bus for the 4:1 byte selector.
// Master drives select and data; slave returns live and registered results.
interface mux_4x8_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;

  modport master (
    output sel, in0, in1, in2, in3,
    input  out, out_q, sel_q
  );

  modport slave (
    input  sel, in0, in1, in2, in3,
    output out, out_q, sel_q
  );
endinterface

// File: rtl/mux_4x8.sv
// Four-input byte selector for the 6502 datapath.
// Combinational out plus a flop-isolated copy tagged with its select.
module mux_4x8 #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  mux_4x8_if.slave   bus
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_d;
  logic [1:0]       sel_q;

  // Unknown select yields X rather than silently picking in0.
  always_comb begin
    data_d = 'x;
    unique case (bus.sel)
      2'b00:   data_d = bus.in0;
      2'b01:   data_d = bus.in1;
      2'b10:   data_d = bus.in2;
      2'b11:   data_d = bus.in3;
      default: data_d = 'x;
    endcase
  end

  assign sel_d = bus.sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= 2'b00;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign bus.out   = data_d;
  assign bus.out_q = data_q;
  assign bus.sel_q = sel_q;

endmodule

// File: tb/tb_mux_4x8.sv
// Directed bench for mux_4x8.
// Covers selection, isolation, registered path and async reset.
module tb_mux_4x8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_trans  = 0;

  mux_4x8_if #(.WIDTH(8)) bus ();

  mux_4x8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(bus.out) n_trans++;

  task automatic set_pattern(input bit b);
    if (!b) begin
      bus.in0 = 8'h00; bus.in1 = 8'h5A;
      bus.in2 = 8'hA5; bus.in3 = 8'hFF;
    end else begin
      bus.in0 = 8'hFF; bus.in1 = 8'hA5;
      bus.in2 = 8'h5A; bus.in3 = 8'h00;
    end
  endtask

  task automatic test_reset();
    bus.sel = 2'b00;
    set_pattern(1'b0);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_q got %h want 00", bus.out_q);
    end
    n_checks++;
    if (bus.sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_sel_q got %b want 00", bus.sel_q);
    end
    n_checks++;
    if (bus.out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out got %h want 00", bus.out);
    end
  endtask

  task automatic test_select();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h00, 8'h5A, 8'hA5, 8'hFF};
    exp_b = '{8'hFF, 8'hA5, 8'h5A, 8'h00};
    for (int s = 0; s < 4; s++) begin
      bus.sel = s[1:0];
      set_pattern(1'b0);
      #1;
      n_checks++;
      if (bus.out !== exp_a[s]) begin
        n_fail++;
        $display("FAIL sel%0d_patA got %h want %h", s, bus.out, exp_a[s]);
      end
      #1 set_pattern(1'b1);
      #1;
      n_checks++;
      if (bus.out !== exp_b[s]) begin
        n_fail++;
        $display("FAIL sel%0d_patB got %h want %h", s, bus.out, exp_b[s]);
      end
    end
  endtask

  task automatic test_isolation();
    logic [7:0] v;
    bus.sel = 2'b01;
    bus.in1 = 8'h3C;
    #1 n_trans = 0;
    for (int i = 0; i < 8; i++) begin
      v = i[0] ? 8'hFF : 8'h00;
      bus.in0 = v;
      bus.in2 = ~v;
      bus.in3 = v;
      #1;
      n_checks++;
      if (bus.out !== 8'h3C) begin
        n_fail++;
        $display("FAIL iso_out step%0d got %h want 3c", i, bus.out);
      end
    end
    n_checks++;
    if (n_trans != 0) begin
      n_fail++;
      $display("FAIL iso_glitch got %0d transitions want 0", n_trans);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b1;
    bus.sel = 2'b10;
    set_pattern(1'b0);
    #1;
    n_checks++;
    if (bus.out !== 8'hA5) begin
      n_fail++;
      $display("FAIL rst_out_tracks got %h want a5", bus.out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_q !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_hold got %h want 00", bus.out_q);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_q !== 8'h00) begin
      n_fail++;
      $display("FAIL pre_edge got %h want 00", bus.out_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_q !== 8'hA5) begin
      n_fail++;
      $display("FAIL first_cap_out got %h want a5", bus.out_q);
    end
    n_checks++;
    if (bus.sel_q !== 2'b10) begin
      n_fail++;
      $display("FAIL first_cap_sel got %b want 10", bus.sel_q);
    end
    @(negedge clk);
    bus.sel = 2'b11;
    #1;
    n_checks++;
    if (bus.out_q !== 8'hA5) begin
      n_fail++;
      $display("FAIL latency got %h want a5", bus.out_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_q !== 8'hFF || bus.sel_q !== 2'b11) begin
      n_fail++;
      $display("FAIL second_cap got %h/%b want ff/11",
               bus.out_q, bus.sel_q);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_q !== 8'h00 || bus.sel_q !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst got %h/%b want 00/00",
               bus.out_q, bus.sel_q);
    end
    n_checks++;
    if (bus.out !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_rst_out got %h want ff", bus.out);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sv  [4];
    logic [7:0] exp [4];
    sv  = '{2'b01, 2'b00, 2'b11, 2'b10};
    exp = '{8'hA5, 8'hFF, 8'h00, 8'h5A};
    @(negedge clk);
    rst = 1'b0;
    set_pattern(1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.sel = sv[i];
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_q !== exp[i] || bus.sel_q !== sv[i]) begin
        n_fail++;
        $display("FAIL b2b%0d got %h/%b want %h/%b",
                 i, bus.out_q, bus.sel_q, exp[i], sv[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_isolation();
    test_registered();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
